uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single UART byte transmitter between NUM_REQ on-chip requesters (sensor reporter, status logger, command echo, ...). It grants the transmitter round-robin, one whole frame at a time. It issues one-cycle data-valid pulses and byte values to the transmitter, then waits for the transmitter's done indication. It never pulses data-valid while the transmitter may still be shifting.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match transmitter
CLKS_PER_BIT, 5208, transmitter bit period in clocks; sizes the post-reset guard
HOLD_CLKS, 1000000, max idle cycles mid-frame before the grant is revoked

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Req_Valid  in  NUM_REQ  requester k has a byte
i_Req_Data  in  NUM_REQ*DATA_W  requester k byte at [k*DATA_W +: DATA_W]
i_Req_Last  in  NUM_REQ  byte from requester k ends its frame
o_Req_Ready  out  NUM_REQ  combinational; byte taken when valid&ready high on a rising edge
o_TX_DV  out  1  one-cycle start pulse to transmitter
o_TX_Byte  out  DATA_W  byte to transmitter; held stable until next o_TX_DV
i_TX_Done  in  1  transmitter done; high 1+ cycles per byte
o_Grant  out  NUM_REQ  one-hot current owner; 0 when none
o_Busy  out  1  frame in progress (state not IDLE/GUARD)
o_Abort  out  1  one-cycle pulse when a grant is revoked by hold timeout

Behaviour:
- Reset (async assert, sync release): state GUARD, counter 0, all outputs 0, rr pointer = NUM_REQ-1 (requester 0 served first).
- States: GUARD, IDLE, SEND, WAIT_DONE, DRAIN.
- GUARD: counts 10*CLKS_PER_BIT+2 cycles, then IDLE. This covers a transmitter still shifting a byte from before reset. Reset mid-frame always re-enters GUARD; the interrupted frame is lost and no ready is given.
- IDLE: if any i_Req_Valid is high, pick the first valid requester after the rr pointer (wrapping modulo NUM_REQ), register o_Grant, and go to SEND. With no valid requester, stay in IDLE with o_Grant=0.
- SEND: o_Req_Ready[g]=1 only here and only for the owner. When valid[g] is high: latch the byte into o_TX_Byte, set o_TX_DV=1 for exactly one cycle, latch last[g], clear the hold counter, and go to WAIT_DONE.
- SEND timeout: if valid[g] is low, the hold counter increments. At HOLD_CLKS: pulse o_Abort, clear o_Grant, set the rr pointer to g, and go to IDLE. The hold counter only runs when at least one byte of the frame has been sent; a fresh grant always has valid high.
- WAIT_DONE: wait for i_TX_Done=1, then go to DRAIN.
- DRAIN: wait for i_TX_Done=0, because done stays high for two cycles. Then:
  - if last was latched: rr pointer = g, o_Grant=0, go to IDLE;
  - otherwise go to SEND with the same owner.
- Latency: valid in IDLE at edge n gives o_Grant at n+1 and o_TX_DV high after edge n+2.
- Frame boundaries: other requesters' valids are ignored until the owner's last byte completes. Once released, the owner has lowest priority in the next pick.
- Simultaneous requests: decided purely by the rr pointer. Valid may drop in any non-SEND cycle without effect.
- o_Busy = state in {SEND, WAIT_DONE, DRAIN}.
- o_TX_DV is never high in any state other than the cycle after a SEND transfer.

Optional Feature:
UART_ARB_PRIO0_EN
- Defined: requester 0 has strict priority in IDLE over the round-robin pick among the rest. It still never pre-empts a frame in progress, and the rr pointer covers requesters 1..NUM_REQ-1 only.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Package uart_arb_pkg: state enum/localparams (GUARD, IDLE, SEND, WAIT_DONE, DRAIN), guard-length function of CLKS_PER_BIT, and counter width via clog2 of max(guard, HOLD_CLKS).
- Sub-module uart_rr_picker: combinational, takes request vector and pointer, returns one-hot grant plus any-request flag.
- Counter, FSM and datapath stay in the top.

Test Plan:
- Reset then req0 valid with a single byte 0x41 (last=1), CLKS_PER_BIT=4: no o_TX_DV for 42 cycles. Then o_Grant=0001, one o_TX_DV with o_TX_Byte=0x41, release after done falls.
- req1 and req2 valid together, each sending one byte (last=1), pointer at 3: req1 is served first (0x11), then req2 (0x22), each with one DV pulse; o_Grant never two-hot.
- req0 sends a 3-byte frame 0xA0,0xA1,0xA2 (last on 3rd) while req3 is valid throughout: all three bytes go out before req3's grant, and there is exactly one DV per done.
- Transmitter model holds done for 2 cycles: no second DV until done is low and the next SEND transfer occurs; the byte count out equals the byte count accepted.
- Owner drops valid after byte 1 with HOLD_CLKS=16: o_Abort pulses 16 cycles into SEND, o_Grant=0, the next requester is served.
- Reset asserted during WAIT_DONE: all outputs 0 immediately, GUARD re-entered, no DV until the guard expires. With UART_ARB_PRIO0_EN defined, req0 and req2 both valid in IDLE: req0 is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmitter arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StGuard,
    StIdle,
    StSend,
    StWaitDone,
    StDrain
  } arb_state_e;

  function automatic int unsigned guard_len(input int unsigned clks_per_bit);
    return 10 * clks_per_bit + 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned clks_per_bit,
                                            input int unsigned hold_clks);
    int unsigned max_cnt;
    max_cnt = (guard_len(clks_per_bit) > hold_clks) ? guard_len(clks_per_bit) : hold_clks;
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first requester after the pointer, wrapping.
module uart_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               any_o
);

  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    // Offset 1 first so the pointer's own requester is checked last.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter in front of a single UART byte transmitter.
// Define UART_ARB_PRIO0_EN to give requester 0 strict priority at each pick.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned HOLD_CLKS    = 1000000
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [NUM_REQ-1:0]        i_Req_Valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]        i_Req_Last,
  output logic [NUM_REQ-1:0]        o_Req_Ready,
  output logic                      o_TX_DV,
  output logic [DATA_W-1:0]         o_TX_Byte,
  input  logic                      i_TX_Done,
  output logic [NUM_REQ-1:0]        o_Grant,
  output logic                      o_Busy,
  output logic                      o_Abort
);

  localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GuardLen = guard_len(CLKS_PER_BIT);
  localparam int unsigned CntW     = cnt_width(CLKS_PER_BIT, HOLD_CLKS);

  arb_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [PtrW-1:0]   ptr_q;
  logic              last_q;
  logic              sent_q;

  logic [NUM_REQ-1:0] rr_req, rr_grant, pick;
  logic               rr_any, any_req;
  logic [PtrW-1:0]    owner_idx;
  logic               owner_valid, owner_last;
  logic [DATA_W-1:0]  owner_byte;
  logic               ptr_upd;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PtrW    (PtrW)
  ) u_picker (
    .req_i   (rr_req),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .any_o   (rr_any)
  );

`ifdef UART_ARB_PRIO0_EN
  // Requester 0 sits outside the rotation; the pointer only tracks 1..NUM_REQ-1.
  assign rr_req  = i_Req_Valid & ~NUM_REQ'(1);
  assign pick    = i_Req_Valid[0] ? NUM_REQ'(1) : rr_grant;
  assign any_req = rr_any | i_Req_Valid[0];
  assign ptr_upd = (owner_idx != '0);
`else
  assign rr_req  = i_Req_Valid;
  assign pick    = rr_grant;
  assign any_req = rr_any;
  assign ptr_upd = 1'b1;
`endif

  always_comb begin
    owner_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (o_Grant[k]) owner_idx = PtrW'(k);
    end
  end

  assign owner_valid = |(i_Req_Valid & o_Grant);
  assign owner_last  = |(i_Req_Last & o_Grant);
  assign owner_byte  = i_Req_Data[owner_idx*DATA_W +: DATA_W];

  assign o_Req_Ready = (state_q == StSend) ? o_Grant : '0;
  assign o_Busy      = (state_q == StSend) || (state_q == StWaitDone) || (state_q == StDrain);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= StGuard;
      cnt_q     <= '0;
      ptr_q     <= PtrW'(NUM_REQ - 1);
      last_q    <= 1'b0;
      sent_q    <= 1'b0;
      o_Grant   <= '0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= '0;
      o_Abort   <= 1'b0;
    end else begin
      o_TX_DV <= 1'b0;
      o_Abort <= 1'b0;
      unique case (state_q)
        StGuard: begin
          if (cnt_q == CntW'(GuardLen - 1)) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (any_req) begin
            o_Grant <= pick;
            sent_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (owner_valid) begin
            o_TX_Byte <= owner_byte;
            o_TX_DV   <= 1'b1;
            last_q    <= owner_last;
            sent_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StWaitDone;
          end else if (sent_q) begin
            // Owner stalled mid-frame: give the transmitter to someone else.
            if (cnt_q == CntW'(HOLD_CLKS - 1)) begin
              o_Abort <= 1'b1;
              o_Grant <= '0;
              if (ptr_upd) ptr_q <= owner_idx;
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StWaitDone: begin
          if (i_TX_Done) state_q <= StDrain;
        end
        StDrain: begin
          if (!i_TX_Done) begin
            if (last_q) begin
              if (ptr_upd) ptr_q <= owner_idx;
              o_Grant <= '0;
              state_q <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StGuard;
      endcase
    end
  end

endmodule
